// File: rtl/la_gate33_bist.sv
// rtl/la_gate33_bist.sv - exhaustive 64-vector BIST sequencer for OAI33/AOI33 compound gates
module la_gate33_bist #(
    parameter string       PROP   = "DEFAULT",
    parameter string       TYPE   = "OAI33",
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    output logic       a0,
    output logic       a1,
    output logic       a2,
    output logic       b0,
    output logic       b1,
    output logic       b2,
    input  logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] errcnt,
    output logic [5:0] failvec,
    output logic       failvld
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_CNT = SETTLE[3:0];
    localparam bit         IS_AOI     = (TYPE == "AOI33");

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_vec;
    logic [3:0] r_cnt;
    logic [6:0] r_errcnt;
    logic [5:0] r_failvec;
    logic       r_failvld;
    logic       r_pass;

    logic       w_exp;
    logic       w_mismatch;
    logic [6:0] w_errcnt_next;
    logic       w_last_vec;

    // PROP only tags the instance for the implementation flow; both arms are empty
    if (PROP == "") begin : g_prop_empty
    end else begin : g_prop_set
    end

    // Golden response of the selected compound gate for the vector currently applied
    always_comb begin
        w_exp = 1'b0;
        if (IS_AOI) begin
            w_exp = ~((&r_vec[2:0]) | (&r_vec[5:3]));
        end else begin
            w_exp = ~((|r_vec[2:0]) & (|r_vec[5:3]));
        end
    end

    assign w_mismatch    = (z != w_exp);
    assign w_errcnt_next = r_errcnt + {6'd0, w_mismatch};
    assign w_last_vec    = (r_vec == 6'd63);

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: one WAIT phase and one CHECK cycle per vector, 64 vectors per run
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_last_vec) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Stimulus, settle counter and result registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_vec     <= 6'd0;
            r_cnt     <= 4'd0;
            r_errcnt  <= 7'd0;
            r_failvec <= 6'd0;
            r_failvld <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec     <= 6'd0;
                        r_cnt     <= SETTLE_CNT;
                        r_errcnt  <= 7'd0;
                        r_failvec <= 6'd0;
                        r_failvld <= 1'b0;
                        r_pass    <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_errcnt <= w_errcnt_next;
                        if (!r_failvld) begin
                            r_failvec <= r_vec;
                            r_failvld <= 1'b1;
                        end
                    end
                    if (w_last_vec) begin
                        // Resolve pass on entry to DONE so it is already valid alongside the done pulse
                        r_pass <= (w_errcnt_next == 7'd0);
                    end else begin
                        r_vec <= r_vec + 6'd1;
                        r_cnt <= SETTLE_CNT;
                    end
                end
                S_DONE: begin
                    r_pass <= (r_errcnt == 7'd0);
                end
                default: begin
                end
            endcase
        end
    end

    assign a0      = r_vec[0];
    assign a1      = r_vec[1];
    assign a2      = r_vec[2];
    assign b0      = r_vec[3];
    assign b1      = r_vec[4];
    assign b2      = r_vec[5];
    assign busy    = (r_state == S_WAIT) || (r_state == S_CHECK);
    assign done    = (r_state == S_DONE);
    assign pass    = r_pass;
    assign errcnt  = r_errcnt;
    assign failvec = r_failvec;
    assign failvld = r_failvld;

endmodule

// File: tb/tb_la_gate33_bist.sv
// tb/tb_la_gate33_bist.sv - directed self-checking bench for la_gate33_bist
module tb_la_gate33_bist;

    logic       clk = 1'b0;
    logic       nreset;
    logic [2:0] start_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] pass_v;
    logic [2:0] failvld_v;
    logic [2:0] z_v;
    logic [5:0] vec_v     [3];
    logic [5:0] failvec_v [3];
    logic [6:0] errcnt_v  [3];
    int         mode_v    [3];
    int         cyc  = 0;
    int         base = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic golden(input bit aoi, input logic [5:0] v);
        if (aoi) return ~((v[0] & v[1] & v[2]) | (v[3] & v[4] & v[5]));
        return ~((v[0] | v[1] | v[2]) & (v[3] | v[4] | v[5]));
    endfunction

    // mode 0 fault-free, 1 stuck-at-0, 2 stuck-at-1, 3 correct only in the expected sampling cycle (SETTLE=3)
    always_comb begin
        z_v = '0;
        for (int i = 0; i < 3; i++) begin
            case (mode_v[i])
                0:       z_v[i] = golden(i == 1, vec_v[i]);
                1:       z_v[i] = 1'b0;
                2:       z_v[i] = 1'b1;
                default: z_v[i] = golden(i == 1, vec_v[i]) ^ (((cyc - base + 1) % 5) != 0);
            endcase
        end
    end

    la_gate33_bist #(.PROP("DEFAULT"), .TYPE("OAI33"), .SETTLE(1)) u_oai_s1 (
        .clk(clk), .nreset(nreset), .start(start_v[0]),
        .a0(vec_v[0][0]), .a1(vec_v[0][1]), .a2(vec_v[0][2]),
        .b0(vec_v[0][3]), .b1(vec_v[0][4]), .b2(vec_v[0][5]),
        .z(z_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .errcnt(errcnt_v[0]), .failvec(failvec_v[0]), .failvld(failvld_v[0])
    );

    la_gate33_bist #(.PROP("DEFAULT"), .TYPE("AOI33"), .SETTLE(0)) u_aoi_s0 (
        .clk(clk), .nreset(nreset), .start(start_v[1]),
        .a0(vec_v[1][0]), .a1(vec_v[1][1]), .a2(vec_v[1][2]),
        .b0(vec_v[1][3]), .b1(vec_v[1][4]), .b2(vec_v[1][5]),
        .z(z_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .errcnt(errcnt_v[1]), .failvec(failvec_v[1]), .failvld(failvld_v[1])
    );

    la_gate33_bist #(.PROP("DEFAULT"), .TYPE("OAI33"), .SETTLE(3)) u_oai_s3 (
        .clk(clk), .nreset(nreset), .start(start_v[2]),
        .a0(vec_v[2][0]), .a1(vec_v[2][1]), .a2(vec_v[2][2]),
        .b0(vec_v[2][3]), .b1(vec_v[2][4]), .b2(vec_v[2][5]),
        .z(z_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .errcnt(errcnt_v[2]), .failvec(failvec_v[2]), .failvld(failvld_v[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input int idx, input string tag);
        chk({tag, "_vec"},     32'(vec_v[idx]),     0);
        chk({tag, "_busy"},    32'(busy_v[idx]),    0);
        chk({tag, "_done"},    32'(done_v[idx]),    0);
        chk({tag, "_pass"},    32'(pass_v[idx]),    0);
        chk({tag, "_errcnt"},  32'(errcnt_v[idx]),  0);
        chk({tag, "_failvec"}, 32'(failvec_v[idx]), 0);
        chk({tag, "_failvld"}, 32'(failvld_v[idx]), 0);
    endtask

    // Pulse start, then count edges after edge 0 until done is seen; returns in the DONE cycle
    task automatic run_full(input int idx, input int exp_edges, input string tag);
        int edges;
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
        chk({tag, "_busy_e0"}, 32'(busy_v[idx]), 1);
        chk({tag, "_vec_e0"},  32'(vec_v[idx]),  0);
        edges = 0;
        while (done_v[idx] !== 1'b1 && edges < exp_edges + 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, "_done_edge"}, edges, exp_edges);
        chk({tag, "_busy_in_done"}, 32'(busy_v[idx]), 0);
    endtask

    task automatic step_idle(input int idx, input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_cleared"}, 32'(done_v[idx]), 0);
        chk({tag, "_idle_busy"},    32'(busy_v[idx]), 0);
    endtask

    initial begin
        int n;
        int edges;
        int busy_gaps;
        nreset  = 1'b0;
        start_v = '0;
        for (int i = 0; i < 3; i++) mode_v[i] = 0;
        #3;
        chk_reset_vals(0, "rst");
        chk_reset_vals(2, "rst2");
        #10;
        @(negedge clk);
        nreset = 1'b1;

        // OAI33 SETTLE=1 fault-free
        mode_v[0] = 0;
        run_full(0, 192, "oai_ok");
        chk("oai_ok_pass",    32'(pass_v[0]),    1);
        chk("oai_ok_errcnt",  32'(errcnt_v[0]),  0);
        chk("oai_ok_failvld", 32'(failvld_v[0]), 0);
        chk("oai_ok_vec_end", 32'(vec_v[0]),     63);
        step_idle(0, "oai_ok");
        chk("oai_ok_pass_hold", 32'(pass_v[0]), 1);

        // OAI33 z stuck-at-0
        mode_v[0] = 1;
        run_full(0, 192, "oai_sa0");
        chk("oai_sa0_errcnt",  32'(errcnt_v[0]),  15);
        chk("oai_sa0_failvec", 32'(failvec_v[0]), 0);
        chk("oai_sa0_failvld", 32'(failvld_v[0]), 1);
        chk("oai_sa0_pass",    32'(pass_v[0]),    0);
        step_idle(0, "oai_sa0");
        chk("oai_sa0_errcnt_hold", 32'(errcnt_v[0]), 15);

        // OAI33 z stuck-at-1
        mode_v[0] = 2;
        run_full(0, 192, "oai_sa1");
        chk("oai_sa1_errcnt",  32'(errcnt_v[0]),  49);
        chk("oai_sa1_failvec", 32'(failvec_v[0]), 9);
        chk("oai_sa1_failvld", 32'(failvld_v[0]), 1);
        chk("oai_sa1_pass",    32'(pass_v[0]),    0);
        step_idle(0, "oai_sa1");

        // AOI33 SETTLE=0 fault-free and stuck-at-0
        mode_v[1] = 0;
        run_full(1, 128, "aoi_ok");
        chk("aoi_ok_pass",   32'(pass_v[1]),   1);
        chk("aoi_ok_errcnt", 32'(errcnt_v[1]), 0);
        step_idle(1, "aoi_ok");
        mode_v[1] = 1;
        run_full(1, 128, "aoi_sa0");
        chk("aoi_sa0_errcnt",  32'(errcnt_v[1]),  49);
        chk("aoi_sa0_failvec", 32'(failvec_v[1]), 0);
        chk("aoi_sa0_pass",    32'(pass_v[1]),    0);
        step_idle(1, "aoi_sa0");

        // Reset in the middle of a run at vec=20
        mode_v[0] = 1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        n = 0;
        while (vec_v[0] !== 6'd20 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_reached_vec20", 32'(vec_v[0]), 20);
        chk("mid_busy_before",   32'(busy_v[0]), 1);
        #2;
        nreset = 1'b0;
        #1;
        chk_reset_vals(0, "mid_rst");
        @(negedge clk);
        nreset = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) n++;
        end
        chk("mid_no_done_after_rst", n, 0);
        mode_v[0] = 0;
        run_full(0, 192, "post_rst");
        chk("post_rst_pass",   32'(pass_v[0]),   1);
        chk("post_rst_errcnt", 32'(errcnt_v[0]), 0);
        step_idle(0, "post_rst");

        // start held high on SETTLE=3: one run with stuck-at-0, relaunch, then timing-sensitive z
        mode_v[2] = 1;
        @(negedge clk);
        start_v[2] = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_busy_e0", 32'(busy_v[2]), 1);
        edges = 0;
        busy_gaps = 0;
        while (done_v[2] !== 1'b1 && edges < 400) begin
            @(posedge clk);
            #1;
            edges++;
            if (done_v[2] !== 1'b1 && busy_v[2] !== 1'b1) busy_gaps++;
        end
        chk("hold_done_edge", edges, 320);
        chk("hold_busy_gaps", busy_gaps, 0);
        chk("hold_errcnt",    32'(errcnt_v[2]),  15);
        chk("hold_failvec",   32'(failvec_v[2]), 0);
        chk("hold_pass",      32'(pass_v[2]),    0);
        @(posedge clk);
        #1;
        chk("hold_idle_busy",   32'(busy_v[2]),   0);
        chk("hold_idle_done",   32'(done_v[2]),   0);
        chk("hold_idle_errcnt", 32'(errcnt_v[2]), 15);
        @(posedge clk);
        #1;
        base = cyc;
        mode_v[2] = 3;
        start_v[2] = 1'b0;
        chk("relaunch_busy",    32'(busy_v[2]),    1);
        chk("relaunch_errcnt",  32'(errcnt_v[2]),  0);
        chk("relaunch_failvld", 32'(failvld_v[2]), 0);
        chk("relaunch_pass",    32'(pass_v[2]),    0);
        chk("relaunch_vec",     32'(vec_v[2]),     0);
        edges = 0;
        while (done_v[2] !== 1'b1 && edges < 400) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("timed_done_edge", edges, 320);
        chk("timed_errcnt",    32'(errcnt_v[2]),  0);
        chk("timed_failvld",   32'(failvld_v[2]), 0);
        chk("timed_pass",      32'(pass_v[2]),    1);
        step_idle(2, "timed");
        @(posedge clk);
        #1;
        chk("timed_no_relaunch", 32'(busy_v[2]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/la_gate33_bist.md
# la_gate33_bist

Built-in self-test sequencer for three-plus-three input compound gates (OAI33 / AOI33). It drives all 64 input combinations into a gate instance, samples the gate output after a programmable settle time, compares each sample against a golden model, and reports pass/fail, the error count and the first failing vector. It sits next to a stdlib gate instance in cell-characterization and silicon-bringup test structures, and drives the gate inputs that the gate consumes.

## Interface
Parameters:
- PROP, "DEFAULT", implementation property string; passed through with no functional effect.
- TYPE, "OAI33", golden model selector:
  - "OAI33": exp = ~((a0|a1|a2)&(b0|b1|b2)).
  - "AOI33": exp = ~((a0&a1&a2)|(b0&b1&b2)).
- SETTLE, 1, number of idle cycles between applying a vector and sampling z. Legal range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- nreset  in  1  asynchronous active-low reset.
- start  in  1  level, sampled each cycle; a run begins only when the block is in IDLE.
- a0, a1, a2, b0, b1, b2  out  1 each  registered stimulus driven into the gate under test.
- z  in  1  gate-under-test output; sampled only in CHECK.
- busy  out  1  high in WAIT and CHECK.
- done  out  1  one-cycle pulse in DONE.
- pass  out  1  result of the last completed run.
- errcnt  out  7  mismatch count of the current or last run, range 0..64.
- failvec  out  6  first mismatching vector, as {b2,b1,b0,a2,a1,a0}.
- failvld  out  1  high once failvec holds a captured vector.

## Operation
- 6-bit vector register vec maps to the stimulus outputs: vec[0]=a0, vec[1]=a1, vec[2]=a2, vec[3]=b0, vec[4]=b1, vec[5]=b2.
- 4-bit settle counter cnt.
- State machine: IDLE, WAIT, CHECK, DONE.
- IDLE, with start=1:
  - vec<=0, cnt<=SETTLE.
  - errcnt<=0, failvld<=0, failvec<=0, pass<=0.
  - Go to WAIT.
- WAIT: if cnt==0, go to CHECK; else cnt<=cnt-1.
- CHECK:
  - Compute exp(vec) from the TYPE model.
  - On mismatch (z!=exp): errcnt<=errcnt+1. If failvld==0, also failvec<=vec and failvld<=1.
  - If vec==63, go to DONE. Otherwise vec<=vec+1, cnt<=SETTLE, go to WAIT.
- DONE: done=1 and pass<=(errcnt==0). Note that errcnt already includes the last CHECK. Go to IDLE.
- vec does not wrap. The 64th CHECK always exits to DONE.
- errcnt cannot exceed 64, so no saturation logic is needed.
- start is ignored in WAIT, CHECK and DONE. A start held high across DONE relaunches in the following IDLE cycle.
- errcnt, failvec, failvld and pass hold their values in IDLE until the next accepted start.
- vec holds its last value (63) after a run, until the next start or reset.
- Unsupported TYPE or SETTLE>15 is a configuration error; behaviour is undefined.

## Timing
- Reset (nreset=0, asynchronous, effective immediately):
  - state=IDLE, vec=0, so all stimulus outputs are 0.
  - cnt=0, busy=0, done=0, pass=0, errcnt=0, failvec=0, failvld=0.
- Reset mid-run aborts the run with no done pulse. Deassertion takes effect at the next clk edge.
- All outputs are registered. busy and done are decoded directly from the state register.
- Take edge 0 as the edge that accepts start:
  - vec=0 is applied after edge 0.
  - Each vector occupies SETTLE+1 WAIT cycles plus 1 CHECK cycle, i.e. SETTLE+2 cycles.
  - z sampling for vector k occurs at edge (k+1)(SETTLE+2).
  - DONE is entered at edge 64(SETTLE+2); done and pass are visible in that cycle.
  - IDLE is re-entered at edge 64(SETTLE+2)+1.
- z is treated as synchronous. It must be stable SETTLE+1 cycles after each vec update.

## Test plan
- Fault-free OAI33 model, SETTLE=1, start pulse → busy rises after edge 0; done at edge 192; pass=1, errcnt=0, failvld=0.
- z stuck-at-0, TYPE="OAI33" → errcnt=15, failvec=6'd0, failvld=1, pass=0.
- z stuck-at-1, TYPE="OAI33" → errcnt=49, failvec=6'd9, pass=0.
- TYPE="AOI33", SETTLE=0:
  - Fault-free → done at edge 128, pass=1.
  - z stuck-at-0 → errcnt=49, failvec=6'd0.
- nreset pulsed while vec=20 → all outputs return to reset values immediately and no done pulse follows. A new start then runs the full 64 vectors from vec=0.
- start held high throughout a run → start ignored while busy, single done pulse, relaunch in the IDLE cycle after DONE clears errcnt/failvld/pass. Compare the per-vector z sample timing against the formula (k+1)(SETTLE+2) with SETTLE=3.
